// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl_pkg
// Purpose  : Forward-select codes and default sizing for the ID hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
package id_hazard_ctrl_pkg;

  localparam int NREG_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 2;

  typedef enum logic [1:0] {
    FWD_SEL_RF = 2'd0,
    FWD_SEL_ES = 2'd1,
    FWD_SEL_MS = 2'd2,
    FWD_SEL_WS = 2'd3
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/hazard_src_resolve.sv
`default_nettype none
// ============================================================================
// Module   : hazard_src_resolve
// Purpose  : Picks the youngest in-flight producer of one busy source operand.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_src_resolve
  import id_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_use,
  input  logic       i_busy,
  input  logic       i_es_valid,
  input  logic [4:0] i_es_dest,
  input  logic       i_es_gr_we,
  input  logic       i_es_is_load,
  input  logic       i_ms_valid,
  input  logic [4:0] i_ms_dest,
  input  logic       i_ms_gr_we,
  input  logic       i_ws_valid,
  input  logic [4:0] i_ws_dest,
  input  logic       i_ws_gr_we,
  output logic [1:0] o_fwd_sel,
  output logic       o_stall,
  output logic       o_load_use
);

  always_comb begin
    o_fwd_sel  = FWD_SEL_RF;
    o_stall    = 1'b0;
    o_load_use = 1'b0;
    if (i_use && i_busy) begin
      if (i_es_valid && i_es_gr_we && (i_es_dest == i_src)) begin
        // Load data is not available until MEM, so the youngest match wins and stalls.
        if (i_es_is_load) begin
          o_stall    = 1'b1;
          o_load_use = 1'b1;
        end else begin
          o_fwd_sel = FWD_SEL_ES;
        end
      end else if (i_ms_valid && i_ms_gr_we && (i_ms_dest == i_src)) begin
        o_fwd_sel = FWD_SEL_MS;
      end else if (i_ws_valid && i_ws_gr_we && (i_ws_dest == i_src)) begin
        o_fwd_sel = FWD_SEL_WS;
      end else begin
        o_stall = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Purpose  : Decode-stage interlock/forwarding control from an in-flight write
//            scoreboard. HAZARD_STATS_EN adds stall_cycles / load_use_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_valid,
  input  logic [4:0]  ds_rj,
  input  logic [4:0]  ds_rkd,
  input  logic        ds_use_rj,
  input  logic        ds_use_rkd,
  input  logic [4:0]  ds_dest,
  input  logic        ds_gr_we,
  input  logic        es_allowin,
  input  logic        es_valid,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic        es_is_load,
  input  logic        ms_valid,
  input  logic [4:0]  ms_dest,
  input  logic        ms_gr_we,
  input  logic        ws_valid,
  input  logic [4:0]  ws_dest,
  input  logic        ws_gr_we,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] load_use_cnt,
`endif
  output logic        ds_ready_go,
  output logic        ds_fire,
  output logic [1:0]  fwd_sel_rj,
  output logic [1:0]  fwd_sel_rkd,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [NREG];
  logic             r_sb_err;

  logic [CNT_W-1:0] w_cnt_rj, w_cnt_rkd, w_cnt_dest, w_cnt_ws;
  logic             w_busy_rj, w_busy_rkd;
  logic             w_stall_rj, w_stall_rkd, w_lu_rj, w_lu_rkd;
  logic             w_inc, w_ret, w_same_reg, w_sat, w_err;

  assign w_cnt_rj   = r_cnt[ds_rj];
  assign w_cnt_rkd  = r_cnt[ds_rkd];
  assign w_cnt_dest = r_cnt[ds_dest];
  assign w_cnt_ws   = r_cnt[ws_dest];

  assign w_busy_rj  = ds_use_rj  && (ds_rj  != 5'd0) && (w_cnt_rj  != '0);
  assign w_busy_rkd = ds_use_rkd && (ds_rkd != 5'd0) && (w_cnt_rkd != '0);

  hazard_src_resolve u_res_rj (
    .i_src(ds_rj), .i_use(ds_use_rj), .i_busy(w_busy_rj),
    .i_es_valid(es_valid), .i_es_dest(es_dest), .i_es_gr_we(es_gr_we), .i_es_is_load(es_is_load),
    .i_ms_valid(ms_valid), .i_ms_dest(ms_dest), .i_ms_gr_we(ms_gr_we),
    .i_ws_valid(ws_valid), .i_ws_dest(ws_dest), .i_ws_gr_we(ws_gr_we),
    .o_fwd_sel(fwd_sel_rj), .o_stall(w_stall_rj), .o_load_use(w_lu_rj)
  );

  hazard_src_resolve u_res_rkd (
    .i_src(ds_rkd), .i_use(ds_use_rkd), .i_busy(w_busy_rkd),
    .i_es_valid(es_valid), .i_es_dest(es_dest), .i_es_gr_we(es_gr_we), .i_es_is_load(es_is_load),
    .i_ms_valid(ms_valid), .i_ms_dest(ms_dest), .i_ms_gr_we(ms_gr_we),
    .i_ws_valid(ws_valid), .i_ws_dest(ws_dest), .i_ws_gr_we(ws_gr_we),
    .o_fwd_sel(fwd_sel_rkd), .o_stall(w_stall_rkd), .o_load_use(w_lu_rkd)
  );

  assign w_ret      = ws_valid && ws_gr_we && (ws_dest != 5'd0);
  assign w_same_reg = (ws_dest == ds_dest);

  // A full counter may still take a new writer when the same register retires this cycle.
  assign w_sat = ds_gr_we && (ds_dest != 5'd0) && (w_cnt_dest == C_CNT_MAX) &&
                 !(w_ret && w_same_reg);

  assign ds_ready_go = !(w_stall_rj || w_stall_rkd || w_sat);
  assign ds_fire     = ds_valid && ds_ready_go && es_allowin;
  assign w_inc       = ds_fire && ds_gr_we && (ds_dest != 5'd0);

  assign w_err = (w_ret && (w_cnt_ws == '0)) ||
                 (w_inc && (w_cnt_dest == C_CNT_MAX) && !(w_ret && w_same_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      // Counters hold at their limits on inconsistent traffic; sb_err records it.
      if (w_inc && !(w_ret && w_same_reg) && (w_cnt_dest != C_CNT_MAX))
        r_cnt[ds_dest] <= w_cnt_dest + 1'b1;
      if (w_ret && !(w_inc && w_same_reg) && (w_cnt_ws != '0))
        r_cnt[ws_dest] <= w_cnt_ws - 1'b1;
      if (w_err)
        r_sb_err <= 1'b1;
    end
  end

  assign sb_err = r_sb_err;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles, r_load_use_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_load_use_cnt <= '0;
    end else begin
      if (ds_valid && !ds_ready_go)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (ds_valid && (w_lu_rj || w_lu_rkd))
        r_load_use_cnt <= r_load_use_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign load_use_cnt = r_load_use_cnt;
`else
  logic w_unused_lu;
  assign w_unused_lu = w_lu_rj ^ w_lu_rkd;
`endif

endmodule
`default_nettype wire
